// File: rtl/uturn_sequencer_pkg.sv
// Shared types and constants for the U-turn sequencer.
package uturn_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StBlind,
    StSeek,
    StSettle,
    StDone,
    StFault
  } uturn_state_e;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  // Index of the centre reflectance sensor in line_sensors
  localparam int unsigned CENTRE = 2;

  // Consecutive centre hits needed to accept the line as reacquired
  localparam int unsigned DEBOUNCE_LEN = 3;

  // Width of a counter that must hold 0..max_val; never narrower than 1 bit
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/uturn_sequencer_sensor_debounce.sv
// N-consecutive-ones filter: hit_o rises on the Len-th consecutive high sample.
module uturn_sequencer_sensor_debounce
  import uturn_sequencer_pkg::*;
#(
  parameter int unsigned Len = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic sample_i,
  output logic hit_o
);

  localparam int unsigned CntW = cnt_width(Len);
  localparam int unsigned CntSat = (Len > 0) ? Len - 1 : 0;

  logic [CntW-1:0] run_q;

  // Length of the current run of high samples, saturating at Len-1
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_q <= '0;
    end else if (clear_i || !sample_i) begin
      run_q <= '0;
    end else if (run_q < CntW'(CntSat)) begin
      run_q <= run_q + CntW'(1);
    end
  end

  assign hit_o = sample_i && !clear_i && (run_q >= CntW'(CntSat));

endmodule

// File: rtl/uturn_sequencer.sv
// In-place U-turn sequencer with motor-command arbitration against the tracking controller.
module uturn_sequencer
  import uturn_sequencer_pkg::*;
#(
  parameter int unsigned BLIND_CYCLES   = 50000,
  parameter int unsigned SETTLE_CYCLES  = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned SPIN_DUTY      = 160,
  parameter int unsigned DUTY_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_uturn,
  input  logic              en_tracking,
  input  logic [4:0]        line_sensors,
  input  logic [DUTY_W-1:0] track_left_duty,
  input  logic [DUTY_W-1:0] track_right_duty,
  input  logic              track_left_dir,
  input  logic              track_right_dir,
  output logic [DUTY_W-1:0] left_duty,
  output logic [DUTY_W-1:0] right_duty,
  output logic              left_dir,
  output logic              right_dir,
  output logic              uturn_finished,
  output logic              uturn_fault
);

  localparam int unsigned BlindW     = cnt_width(BLIND_CYCLES);
  localparam int unsigned SettleW    = cnt_width(SETTLE_CYCLES);
  localparam int unsigned TimeoutW   = cnt_width(TIMEOUT_CYCLES);
  // A zero-length phase still occupies one cycle
  localparam int unsigned BlindLast   = (BLIND_CYCLES > 0) ? BLIND_CYCLES - 1 : 0;
  localparam int unsigned SettleLast  = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
  localparam int unsigned TimeoutLast = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  uturn_state_e         state_q, state_d;
  logic                 en_q;
  logic                 start;
  logic                 spinning;
  logic                 line_hit;
  logic                 blind_done, settle_done, timeout_hit;
  logic [BlindW-1:0]    blind_cnt_q;
  logic [SettleW-1:0]   settle_cnt_q;
  logic [TimeoutW-1:0]  timeout_cnt_q;
  logic                 unused_sensors;

  // Only the centre sensor steers the sequence
  assign unused_sensors = ^{line_sensors[4:3], line_sensors[1:0]};

  assign start       = (state_q == StIdle) && en_uturn && !en_q;
  assign spinning    = (state_q == StBlind) || (state_q == StSeek);
  assign blind_done  = blind_cnt_q >= BlindW'(BlindLast);
  assign settle_done = settle_cnt_q >= SettleW'(SettleLast);
  assign timeout_hit = timeout_cnt_q >= TimeoutW'(TimeoutLast);

  // History is held clear outside SEEK so every SEEK starts from an empty run
  uturn_sequencer_sensor_debounce #(
    .Len (DEBOUNCE_LEN)
  ) u_centre_debounce (
    .clk_i    (clk),
    .rst_i    (rst),
    .clear_i  (state_q != StSeek),
    .sample_i (line_sensors[CENTRE]),
    .hit_o    (line_hit)
  );

  // Phase timers: blind/settle restart on entry, timeout spans BLIND+SEEK from start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blind_cnt_q   <= '0;
      settle_cnt_q  <= '0;
      timeout_cnt_q <= '0;
    end else begin
      if (state_q != StBlind) begin
        blind_cnt_q <= '0;
      end else if (blind_cnt_q != BlindW'(BLIND_CYCLES)) begin
        blind_cnt_q <= blind_cnt_q + BlindW'(1);
      end

      if (state_q != StSettle) begin
        settle_cnt_q <= '0;
      end else if (settle_cnt_q != SettleW'(SETTLE_CYCLES)) begin
        settle_cnt_q <= settle_cnt_q + SettleW'(1);
      end

      if (start) begin
        timeout_cnt_q <= '0;
      end else if (spinning && (timeout_cnt_q != TimeoutW'(TIMEOUT_CYCLES))) begin
        timeout_cnt_q <= timeout_cnt_q + TimeoutW'(1);
      end
    end
  end

  // Next state; abort beats everything, line reacquisition beats timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) state_d = StBlind;
      end
      StBlind: begin
        if (!en_uturn)        state_d = StIdle;
        else if (timeout_hit) state_d = StFault;
        else if (blind_done)  state_d = StSeek;
      end
      StSeek: begin
        if (!en_uturn)        state_d = StIdle;
        else if (line_hit)    state_d = StSettle;
        else if (timeout_hit) state_d = StFault;
      end
      StSettle: begin
        if (!en_uturn)        state_d = StIdle;
        else if (settle_done) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs, decoded from the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      en_q           <= 1'b0;
      left_duty      <= '0;
      right_duty     <= '0;
      left_dir       <= DIR_FWD;
      right_dir      <= DIR_FWD;
      uturn_finished <= 1'b0;
      uturn_fault    <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_uturn;

      case (state_d)
        StIdle: begin
          if (en_tracking) begin
            left_duty  <= track_left_duty;
            right_duty <= track_right_duty;
            left_dir   <= track_left_dir;
            right_dir  <= track_right_dir;
          end else begin
            left_duty  <= '0;
            right_duty <= '0;
            left_dir   <= DIR_FWD;
            right_dir  <= DIR_FWD;
          end
        end
        StBlind, StSeek: begin
          left_duty  <= DUTY_W'(SPIN_DUTY);
          right_duty <= DUTY_W'(SPIN_DUTY);
          left_dir   <= DIR_REV;
          right_dir  <= DIR_FWD;
        end
        default: begin
          left_duty  <= '0;
          right_duty <= '0;
          left_dir   <= DIR_FWD;
          right_dir  <= DIR_FWD;
        end
      endcase

      uturn_finished <= (state_d == StDone) || (state_d == StFault);

      if (start) begin
        uturn_fault <= 1'b0;
      end else if (state_d == StFault) begin
        uturn_fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uturn_sequencer.sv
// Randomized bench for uturn_sequencer against a phase/age reference model.
module tb_uturn_sequencer;

  localparam int BLIND   = 10;
  localparam int SETTLE  = 5;
  localparam int TIMEOUT = 100;
  localparam int SPIN    = 160;
  localparam int DW      = 8;

  localparam int PH_IDLE   = 0;
  localparam int PH_SPIN   = 1;
  localparam int PH_SETTLE = 2;
  localparam int PH_END    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          en_uturn;
  logic          en_tracking;
  logic [4:0]    line_sensors;
  logic [DW-1:0] track_left_duty;
  logic [DW-1:0] track_right_duty;
  logic          track_left_dir;
  logic          track_right_dir;
  logic [DW-1:0] left_duty;
  logic [DW-1:0] right_duty;
  logic          left_dir;
  logic          right_dir;
  logic          uturn_finished;
  logic          uturn_fault;

  always #5 clk = ~clk;

  uturn_sequencer #(
    .BLIND_CYCLES   (BLIND),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT),
    .SPIN_DUTY      (SPIN),
    .DUTY_W         (DW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .en_uturn         (en_uturn),
    .en_tracking      (en_tracking),
    .line_sensors     (line_sensors),
    .track_left_duty  (track_left_duty),
    .track_right_duty (track_right_duty),
    .track_left_dir   (track_left_dir),
    .track_right_dir  (track_right_dir),
    .left_duty        (left_duty),
    .right_duty       (right_duty),
    .left_dir         (left_dir),
    .right_dir        (right_dir),
    .uturn_finished   (uturn_finished),
    .uturn_fault      (uturn_fault)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a turn is "spinning" for age cycles; the first BLIND of them
  // ignore the line, then three consecutive centre hits end the spin.
  int   m_phase;
  int   m_age;
  int   m_run;
  int   m_settle;
  bit   m_prev_en;
  bit   m_fault;
  logic [DW-1:0] e_ld, e_rd;
  logic e_ldir, e_rdir, e_fin;

  task automatic model_reset();
    m_phase   = PH_IDLE;
    m_age     = 0;
    m_run     = 0;
    m_settle  = 0;
    m_prev_en = 1'b0;
    m_fault   = 1'b0;
  endtask

  task automatic model_step();
    bit rise;
    bit seeking;
    rise = en_uturn && !m_prev_en;
    case (m_phase)
      PH_IDLE: begin
        if (rise) begin
          m_phase = PH_SPIN;
          m_age   = 0;
          m_run   = 0;
          m_fault = 1'b0;
        end
      end
      PH_SPIN: begin
        if (!en_uturn) begin
          m_phase = PH_IDLE;
        end else begin
          seeking = (m_age >= BLIND);
          m_run   = (seeking && line_sensors[2]) ? m_run + 1 : 0;
          m_age++;
          if (m_run >= 3) begin
            m_phase  = PH_SETTLE;
            m_settle = 0;
          end else if (m_age >= TIMEOUT) begin
            m_phase = PH_END;
            m_fault = 1'b1;
          end
        end
      end
      PH_SETTLE: begin
        if (!en_uturn) begin
          m_phase = PH_IDLE;
        end else begin
          m_settle++;
          if (m_settle >= SETTLE) m_phase = PH_END;
        end
      end
      default: m_phase = PH_IDLE;
    endcase
    m_prev_en = en_uturn;

    e_fin = (m_phase == PH_END);
    if (m_phase == PH_IDLE && en_tracking) begin
      e_ld = track_left_duty;  e_rd = track_right_duty;
      e_ldir = track_left_dir; e_rdir = track_right_dir;
    end else if (m_phase == PH_SPIN) begin
      e_ld = DW'(SPIN); e_rd = DW'(SPIN);
      e_ldir = 1'b0;    e_rdir = 1'b1;
    end else begin
      e_ld = '0;     e_rd = '0;
      e_ldir = 1'b1; e_rdir = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("left_duty", 32'(left_duty), 32'(e_ld));
    check_eq("right_duty", 32'(right_duty), 32'(e_rd));
    check_eq("left_dir", 32'(left_dir), 32'(e_ldir));
    check_eq("right_dir", 32'(right_dir), 32'(e_rdir));
    check_eq("uturn_finished", 32'(uturn_finished), 32'(e_fin));
    check_eq("uturn_fault", 32'(uturn_fault), 32'(m_fault));
  endtask

  task automatic rand_track();
    en_tracking      = ($urandom_range(0, 1) == 1);
    track_left_duty  = DW'($urandom);
    track_right_duty = DW'($urandom);
    track_left_dir   = ($urandom_range(0, 1) == 1);
    track_right_dir  = ($urandom_range(0, 1) == 1);
    line_sensors     = 5'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    en_uturn = 1'b0;
    for (int i = 0; i < n; i++) begin
      rand_track();
      tick();
    end
  endtask

  // kind 0: glitches in blind, 2-cycle pulse in seek, then line held
  // kind 1: runs of two only -> timeout; kind 2: abort; kind 3: noisy centre
  function automatic bit centre_for(input int kind, input int c);
    case (kind)
      0:       return (c >= 3 && c <= 6) || c == 14 || c == 15 || c >= 20;
      1:       return (c % 3) != 0;
      2:       return $urandom_range(0, 3) == 0;
      default: return $urandom_range(0, 1) == 1;
    endcase
  endfunction

  task automatic run_turn(input int kind);
    int abort_at;
    int tail;
    abort_at = (kind == 2) ? int'($urandom_range(12, 30)) : -1;
    tail     = 0;
    en_uturn = 1'b1;
    for (int c = 0; c < 150 && tail < 3; c++) begin
      rand_track();
      line_sensors[2] = centre_for(kind, c);
      if (c == abort_at) en_uturn = 1'b0;
      tick();
      if (m_phase == PH_IDLE) tail++;
    end
    en_uturn = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    en_uturn         = 1'b0;
    en_tracking      = 1'b0;
    line_sensors     = '0;
    track_left_duty  = '0;
    track_right_duty = '0;
    track_left_dir   = 1'b1;
    track_right_dir  = 1'b1;
    model_reset();

    #12;
    check_eq("rst_left_duty", 32'(left_duty), 32'd0);
    check_eq("rst_right_duty", 32'(right_duty), 32'd0);
    check_eq("rst_left_dir", 32'(left_dir), 32'd1);
    check_eq("rst_right_dir", 32'(right_dir), 32'd1);
    check_eq("rst_finished", 32'(uturn_finished), 32'd0);
    check_eq("rst_fault", 32'(uturn_fault), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Pass-through in idle, then tracking released
    idle_cycles(2);
    en_tracking      = 1'b1;
    track_left_duty  = 8'd100;
    track_right_duty = 8'd42;
    track_left_dir   = 1'b1;
    track_right_dir  = 1'b0;
    tick();
    en_tracking = 1'b0;
    tick();

    // Asynchronous reset in the middle of a spin
    en_uturn = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    #3 rst = 1'b1;
    #1;
    check_eq("async_rst_left_duty", 32'(left_duty), 32'd0);
    check_eq("async_rst_right_duty", 32'(right_duty), 32'd0);
    check_eq("async_rst_left_dir", 32'(left_dir), 32'd1);
    check_eq("async_rst_right_dir", 32'(right_dir), 32'd1);
    check_eq("async_rst_finished", 32'(uturn_finished), 32'd0);
    check_eq("async_rst_fault", 32'(uturn_fault), 32'd0);
    @(negedge clk);
    en_uturn = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Directed turns: normal, timeout, normal (clears fault), abort
    idle_cycles(3);
    run_turn(0);
    idle_cycles(3);
    run_turn(1);
    idle_cycles(3);
    run_turn(0);
    idle_cycles(2);
    run_turn(1);
    idle_cycles(2);
    run_turn(2);
    idle_cycles(3);

    for (int ep = 0; ep < 20; ep++) begin
      run_turn(int'($urandom_range(0, 3)));
      idle_cycles(int'($urandom_range(1, 4)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
